systolic_fir_ctrl: RTL and testbench
====================================

Name: systolic_fir_ctrl

Overview:
Sequencer for the inferred systolic FIR datapath. It loads the tap coefficients, gates the datapath clock-enable from a valid/ready sample stream, and tracks in-flight samples with a valid shift register so that output valid aligns with the pipeline latency. It also drains the pipeline with zero samples on a flush request. It sits between the upstream sample source / config master and the FIR tap chain built from the enable-gated delay flops.

Parameters:
DATA_WIDTH, 18, sample width in and out of the datapath
COEF_WIDTH, 18, coefficient width
NUM_TAPS, 8, number of coefficients / taps
LATENCY, 18, datapath depth in enabled cycles from pipe_in to pipe_out (must be >= 1)

Ports:
clk  in  1  clock
aclr  in  1  reset, asynchronous, active-high
cfg_start  in  1  pulse; begin coefficient load (honoured in IDLE only)
coef_valid  in  1  coefficient write valid
coef_ready  out  1  coefficient write ready
coef_data  in  COEF_WIDTH  coefficient value, tap 0 first
coef_we  out  1  per-tap coefficient write strobe to datapath
coef_addr  out  clog2(NUM_TAPS)  tap index for coef_we
coef_data_o  out  COEF_WIDTH  registered coefficient to datapath
run_start  in  1  pulse; enter RUN (honoured in IDLE with coefs_loaded=1)
flush  in  1  pulse; drain pipeline and return to IDLE (honoured in RUN only)
s_valid  in  1  input sample valid
s_ready  out  1  input sample ready
s_data  in  DATA_WIDTH  input sample
pipe_ena  out  1  datapath clock-enable
pipe_in  out  DATA_WIDTH  sample into datapath (combinational)
pipe_out  in  DATA_WIDTH  datapath result
m_valid  out  1  output valid
m_ready  in  1  output ready
m_data  out  DATA_WIDTH  equals pipe_out
state  out  2  IDLE=0, LOAD=1, RUN=2, FLUSH=3
coefs_loaded  out  1  full coefficient set written since reset

Behaviour:
- Reset: state=IDLE; coefs_loaded=0; coef_we=0; coef_addr=0; coef_data_o=0; vld_sr=0; out_pending=0. Hence m_valid=0, s_ready=0, pipe_ena=0, coef_ready=0.
- IDLE:
  - cfg_start -> LOAD; coef_addr cleared to 0.
  - Otherwise run_start with coefs_loaded=1 -> RUN.
  - If both arrive in the same cycle, cfg_start wins.
- LOAD:
  - coef_ready=1.
  - Each coef_valid&&coef_ready registers coef_we=1, coef_data_o=coef_data, coef_addr=index, one cycle later; the index then increments.
  - After write NUM_TAPS-1: coefs_loaded<=1, state -> IDLE.
  - cfg_start, run_start and flush are ignored in LOAD.
- out_pending: set when pipe_ena=1 and vld_sr[LATENCY-2] (next top bit) is 1; cleared on m_valid&&m_ready with no advance in that cycle.
- m_valid=out_pending; m_data=pipe_out.
- stall = out_pending && !m_ready.
- RUN:
  - s_ready = !stall.
  - pipe_ena = s_valid && s_ready.
  - pipe_in = s_data.
  - vld_sr shifts left on pipe_ena with bit0=1.
  - No advance without an accepted sample, so no bubbles enter the filter.
  - flush -> FLUSH; a sample accepted in the same cycle is kept.
- FLUSH:
  - s_ready=0.
  - pipe_ena = !stall.
  - pipe_in = 0.
  - vld_sr shifts in 0.
  - When vld_sr==0 and out_pending==0 -> IDLE.
  - If vld_sr==0 on entry, FLUSH lasts 1 cycle.
- Output alignment: the k-th accepted sample produces m_valid after exactly LATENCY advances.
- Backpressure: an output is never dropped. A new advance is only allowed when the held output is consumed in the same cycle (m_ready=1).
- LATENCY=1: vld_sr is a single bit and the next-top bit is the input bit.
- aclr mid-operation aborts any state immediately. coefs_loaded clears, and partially loaded coefficients are invalid.
- All outputs are registered except s_ready, pipe_ena, pipe_in, m_data.

Test Plan:
- Load, NUM_TAPS=4: cfg_start, coefs 1,2,3,4 with a gap after the 2nd -> coef_we x4 at addr 0..3 with data 1..4; coefs_loaded=1; state returns to 0.
- run_start with coefs_loaded=0 -> state stays IDLE, s_ready=0. Then load, run_start -> state=2, s_ready=1.
- Stream, LATENCY=4, m_ready=1: 6 back-to-back samples -> pipe_ena high 6 cycles; first m_valid on the 4th advance; 3 m_valid beats total until flush.
- Backpressure: m_ready=0 once m_valid=1 -> s_ready=0, pipe_ena=0, m_data stable. Release -> one beat consumed and advance in the same cycle, no loss or duplication.
- Flush after 6 samples, LATENCY=4: pipe_in=0 with 3 more m_valid beats (6 outputs total), then state=0 with vld_sr=0. Flush in IDLE is ignored.
- aclr asserted mid-RUN with out_pending=1 -> m_valid=0, state=0, coefs_loaded=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/systolic_fir_ctrl_if.sv
// Handshake and datapath bundle between the FIR sequencer and its surroundings.
// The slave view is the sequencer; the master view is the source, sink and datapath.
interface systolic_fir_ctrl_if #(
  parameter int DATA_WIDTH = 18,
  parameter int COEF_WIDTH = 18,
  parameter int NUM_TAPS   = 8
);
  localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  logic                          cfg_start;
  logic                          coef_valid;
  logic                          coef_ready;
  logic signed [COEF_WIDTH-1:0]  coef_data;
  logic                          coef_we;
  logic [AW-1:0]                 coef_addr;
  logic signed [COEF_WIDTH-1:0]  coef_data_o;
  logic                          run_start;
  logic                          flush;
  logic                          s_valid;
  logic                          s_ready;
  logic signed [DATA_WIDTH-1:0]  s_data;
  logic                          pipe_ena;
  logic signed [DATA_WIDTH-1:0]  pipe_in;
  logic signed [DATA_WIDTH-1:0]  pipe_out;
  logic                          m_valid;
  logic                          m_ready;
  logic signed [DATA_WIDTH-1:0]  m_data;
  logic [1:0]                    state;
  logic                          coefs_loaded;

  modport master (
    output cfg_start, coef_valid, coef_data, run_start, flush,
           s_valid, s_data, pipe_out, m_ready,
    input  coef_ready, coef_we, coef_addr, coef_data_o, s_ready,
           pipe_ena, pipe_in, m_valid, m_data, state, coefs_loaded
  );

  modport slave (
    input  cfg_start, coef_valid, coef_data, run_start, flush,
           s_valid, s_data, pipe_out, m_ready,
    output coef_ready, coef_we, coef_addr, coef_data_o, s_ready,
           pipe_ena, pipe_in, m_valid, m_data, state, coefs_loaded
  );
endinterface

// File: rtl/systolic_fir_ctrl.sv
// Sequencer for the systolic FIR: coefficient load, enable gating from the
// sample stream, latency-aligned output valid and zero-sample flush.
module systolic_fir_ctrl #(
  parameter int DATA_WIDTH = 18,
  parameter int COEF_WIDTH = 18,
  parameter int NUM_TAPS   = 8,
  parameter int LATENCY    = 18
) (
  input  logic             clk,
  input  logic             aclr,
  systolic_fir_ctrl_if.slave bus
);
  localparam int AW = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t                       state_q, state_nxt;
  logic [AW-1:0]                load_idx;
  logic [LATENCY-1:0]           vld_sr;
  logic [LATENCY-1:0]           vld_shift;
  logic                         out_pending;
  logic                         coefs_loaded_q;
  logic                         coef_ready_q;
  logic                         coef_we_p0;
  logic [AW-1:0]                coef_addr_p0;
  logic signed [COEF_WIDTH-1:0] coef_data_p0;

  logic                         stall;
  logic                         advance;
  logic                         s_ready_c;
  logic signed [DATA_WIDTH-1:0] pipe_in_c;
  logic                         vld_in;
  logic                         next_top;
  logic                         coef_fire;
  logic                         last_tap;

  assign stall     = out_pending && !bus.m_ready;
  assign coef_fire = coef_ready_q && bus.coef_valid;
  assign last_tap  = (load_idx == AW'(NUM_TAPS - 1));

  // The bit about to reach the top of the valid chain decides out_pending.
  generate
    if (LATENCY == 1) begin : g_lat1
      assign next_top  = vld_in;
      assign vld_shift = vld_in;
    end else begin : g_latn
      assign next_top  = vld_sr[LATENCY-2];
      assign vld_shift = {vld_sr[LATENCY-2:0], vld_in};
    end
  endgenerate

  always_comb begin
    state_nxt = state_q;
    s_ready_c = 1'b0;
    advance   = 1'b0;
    pipe_in_c = '0;
    vld_in    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_start)
          state_nxt = LOAD;
        else if (bus.run_start && coefs_loaded_q)
          state_nxt = RUN;
      end
      LOAD: begin
        if (coef_fire && last_tap)
          state_nxt = IDLE;
      end
      RUN: begin
        s_ready_c = !stall;
        advance   = bus.s_valid && !stall;
        pipe_in_c = bus.s_data;
        vld_in    = 1'b1;
        if (bus.flush)
          state_nxt = FLUSH;
      end
      FLUSH: begin
        // Zeros keep clocking until every in-flight sample has been delivered.
        advance = !stall;
        if ((vld_sr == '0) && !out_pending)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state_q        <= IDLE;
      load_idx       <= '0;
      vld_sr         <= '0;
      out_pending    <= 1'b0;
      coefs_loaded_q <= 1'b0;
      coef_ready_q   <= 1'b0;
      coef_we_p0     <= 1'b0;
      coef_addr_p0   <= '0;
      coef_data_p0   <= '0;
    end else begin
      state_q      <= state_nxt;
      coef_ready_q <= (state_nxt == LOAD);
      coef_we_p0   <= coef_fire;
      if ((state_q == IDLE) && bus.cfg_start) begin
        load_idx     <= '0;
        coef_addr_p0 <= '0;
      end
      if (coef_fire) begin
        coef_addr_p0 <= load_idx;
        coef_data_p0 <= bus.coef_data;
        load_idx     <= load_idx + 1'b1;
        if (last_tap)
          coefs_loaded_q <= 1'b1;
      end
      if (advance) begin
        vld_sr      <= vld_shift;
        out_pending <= next_top;
      end else if (out_pending && bus.m_ready) begin
        out_pending <= 1'b0;
      end
    end
  end

  assign bus.coef_ready   = coef_ready_q;
  assign bus.coef_we      = coef_we_p0;
  assign bus.coef_addr    = coef_addr_p0;
  assign bus.coef_data_o  = coef_data_p0;
  assign bus.s_ready      = s_ready_c;
  assign bus.pipe_ena     = advance;
  assign bus.pipe_in      = pipe_in_c;
  assign bus.m_valid      = out_pending;
  assign bus.m_data       = bus.pipe_out;
  assign bus.state        = state_q;
  assign bus.coefs_loaded = coefs_loaded_q;

endmodule

// File: tb/tb_systolic_fir_ctrl.sv
// Directed bench for systolic_fir_ctrl with a 4-deep enable-gated delay line
// standing in for the FIR datapath.
module tb_systolic_fir_ctrl;
  localparam int DW  = 18;
  localparam int CW  = 18;
  localparam int NT  = 4;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic aclr;
  always #5 clk = ~clk;

  systolic_fir_ctrl_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT)) bus ();

  systolic_fir_ctrl #(
    .DATA_WIDTH(DW), .COEF_WIDTH(CW), .NUM_TAPS(NT), .LATENCY(LAT)
  ) dut (
    .clk (clk),
    .aclr(aclr),
    .bus (bus)
  );

  // Datapath stand-in: LAT enabled stages, output is the sample LAT advances ago.
  logic signed [DW-1:0] dl [LAT];
  always_ff @(posedge clk) begin
    if (bus.pipe_ena) begin
      dl[0] <= bus.pipe_in;
      for (int k = 1; k < LAT; k++) dl[k] <= dl[k-1];
    end
  end
  assign bus.pipe_out = dl[LAT-1];

  int n_vec = 0;
  int n_err = 0;
  int n_adv = 0;
  logic [DW-1:0] beats [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    #1;
    if (bus.m_valid && bus.m_ready) beats.push_back(bus.m_data);
    if (bus.pipe_ena) n_adv++;
    @(negedge clk);
  endtask

  task automatic load_coefs(input bit with_run);
    bus.cfg_start = 1'b1;
    bus.run_start = with_run;
    tick();
    bus.cfg_start = 1'b0;
    bus.run_start = 1'b0;
    chk("load_state", bus.state, 1);
    chk("load_ready", bus.coef_ready, 1);
    chk("load_addr0", bus.coef_addr, 0);
    for (int i = 0; i < NT; i++) begin
      if (i == 2) begin
        bus.coef_valid = 1'b0;
        bus.run_start  = 1'b1;
        bus.flush      = 1'b1;
        tick();
        bus.run_start  = 1'b0;
        bus.flush      = 1'b0;
        chk("load_hold", bus.state, 1);
        chk("gap_we", bus.coef_we, 0);
      end
      bus.coef_valid = 1'b1;
      bus.coef_data  = CW'(i + 1);
      tick();
      chk("coef_we", bus.coef_we, 1);
      chk("coef_addr", bus.coef_addr, i);
      chk("coef_data_o", bus.coef_data_o, i + 1);
    end
    bus.coef_valid = 1'b0;
    chk("load_done_state", bus.state, 0);
    chk("coefs_loaded", bus.coefs_loaded, 1);
    chk("load_done_ready", bus.coef_ready, 0);
  endtask

  initial begin
    aclr           = 1'b0;
    bus.cfg_start  = 1'b0;
    bus.coef_valid = 1'b0;
    bus.coef_data  = '0;
    bus.run_start  = 1'b0;
    bus.flush      = 1'b0;
    bus.s_valid    = 1'b0;
    bus.s_data     = '0;
    bus.m_ready    = 1'b1;
    #2 aclr = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_loaded", bus.coefs_loaded, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_s_ready", bus.s_ready, 0);
    chk("rst_pipe_ena", bus.pipe_ena, 0);
    chk("rst_coef_ready", bus.coef_ready, 0);
    chk("rst_coef_we", bus.coef_we, 0);
    chk("rst_coef_addr", bus.coef_addr, 0);
    chk("rst_coef_data", bus.coef_data_o, 0);
    @(negedge clk);
    aclr = 1'b0;

    // run_start is refused until a coefficient set has been loaded
    bus.run_start = 1'b1;
    tick();
    bus.run_start = 1'b0;
    #1;
    chk("norun_state", bus.state, 0);
    chk("norun_s_ready", bus.s_ready, 0);

    load_coefs(1'b0);

    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("idle_flush", bus.state, 0);

    // cfg_start and run_start together: the reload must win
    load_coefs(1'b1);

    bus.run_start = 1'b1;
    tick();
    bus.run_start = 1'b0;
    #1;
    chk("run_state", bus.state, 2);
    chk("run_s_ready", bus.s_ready, 1);
    chk("run_idle_ena", bus.pipe_ena, 0);

    // stream: first output appears after the 4th advance
    n_adv = 0;
    beats.delete();
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(11 + i);
      #1;
      chk("stream_ena", bus.pipe_ena, 1);
      chk("stream_pipe_in", bus.pipe_in, 11 + i);
      chk("stream_mv_pre", bus.m_valid, 0);
      tick();
    end
    chk("first_mv", bus.m_valid, 1);
    chk("first_mdata", bus.m_data, 11);

    // backpressure holds the output and the pipeline
    bus.m_ready = 1'b0;
    bus.s_data  = DW'(15);
    #1;
    chk("bp_s_ready", bus.s_ready, 0);
    chk("bp_pipe_ena", bus.pipe_ena, 0);
    tick();
    chk("bp_mv", bus.m_valid, 1);
    chk("bp_mdata", bus.m_data, 11);
    #1;
    chk("bp_pipe_ena2", bus.pipe_ena, 0);
    tick();
    bus.m_ready = 1'b1;
    #1;
    chk("rel_s_ready", bus.s_ready, 1);
    chk("rel_pipe_ena", bus.pipe_ena, 1);
    tick();
    chk("rel_mdata", bus.m_data, 12);
    bus.s_data = DW'(16);
    tick();
    chk("stream_adv", n_adv, 6);

    // flush drains the remaining samples with zeros
    bus.s_valid = 1'b0;
    bus.flush   = 1'b1;
    #1;
    chk("flush_req_ena", bus.pipe_ena, 0);
    tick();
    bus.flush = 1'b0;
    #1;
    chk("flush_state", bus.state, 3);
    chk("run_beats", beats.size(), 3);
    chk("flush_s_ready", bus.s_ready, 0);
    chk("flush_ena", bus.pipe_ena, 1);
    chk("flush_pipe_in", bus.pipe_in, 0);
    tick();
    chk("flush_mv", bus.m_valid, 1);
    chk("flush_mdata", bus.m_data, 14);
    bus.m_ready = 1'b0;
    #1;
    chk("flush_stall_ena", bus.pipe_ena, 0);
    tick();
    bus.m_ready = 1'b1;
    chk("flush_stall_mdata", bus.m_data, 14);
    repeat (4) tick();
    chk("flush_done_state", bus.state, 0);
    chk("flush_vld_sr", dut.vld_sr, 0);
    chk("flush_done_mv", bus.m_valid, 0);
    chk("total_beats", beats.size(), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < beats.size()) chk("beat_data", beats[i], 11 + i);
    end

    // asynchronous clear in the middle of RUN with an output pending
    bus.run_start = 1'b1;
    tick();
    bus.run_start = 1'b0;
    chk("rerun_state", bus.state, 2);
    for (int i = 0; i < 4; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = DW'(21 + i);
      tick();
    end
    bus.s_valid = 1'b0;
    chk("pre_aclr_mv", bus.m_valid, 1);
    #2 aclr = 1'b1;
    #1;
    chk("aclr_mv", bus.m_valid, 0);
    chk("aclr_state", bus.state, 0);
    chk("aclr_loaded", bus.coefs_loaded, 0);
    chk("aclr_s_ready", bus.s_ready, 0);
    @(negedge clk);
    aclr = 1'b0;
    bus.run_start = 1'b1;
    tick();
    bus.run_start = 1'b0;
    chk("aclr_norun", bus.state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
